// File: rtl/timer_nch.sv
// Multi-channel down-counting timer on the peripheral bus: per channel CTRL/PRESET/COUNT
// registers, one-shot or auto-reload operation, sticky expiry flag and masked interrupt.
module timer_nch #(
    parameter int          NCH   = 2,
    parameter int          WIDTH = 32,
    parameter logic [31:0] BASE  = 32'h0000_7F00
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [31:2]    addr,
    input  logic [31:0]    wdata,
    input  logic           we,
    output logic [31:0]    rdata,
    output logic [NCH-1:0] irq,
    output logic           irq_any
);
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_CNT, S_INT} state_t;

    logic [31:0] byte_addr;
    logic [31:0] offset;
    logic        hit;
    logic [2:0]  ch_sel;
    logic [1:0]  word_sel;

    logic [31:0] ctrl_rd   [NCH];
    logic [31:0] preset_rd [NCH];
    logic [31:0] count_rd  [NCH];

    assign byte_addr = {addr, 2'b00};
    assign offset    = byte_addr - BASE;
    // The lower-bound test keeps addresses below BASE from aliasing via wrap-around.
    assign hit       = (byte_addr >= BASE) && (offset < 32'(16 * NCH));
    assign ch_sel    = offset[6:4];
    assign word_sel  = offset[3:2];

    for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
        state_t           state_q, state_d;
        logic             en_q, en_d;
        logic [1:0]       mode_q, mode_d;
        logic             im_q, im_d;
        logic             flag_q, flag_d;
        logic [WIDTH-1:0] preset_q, preset_d;
        logic [WIDTH-1:0] count_q, count_d;
        logic             sel;
        logic             wr_ctrl;
        logic             wr_preset;

        assign sel       = hit && (ch_sel == 3'(gi));
        assign wr_ctrl   = we && sel && (word_sel == 2'd0);
        assign wr_preset = we && sel && (word_sel == 2'd1);

        always_comb begin
            state_d  = state_q;
            en_d     = en_q;
            mode_d   = mode_q;
            im_d     = im_q;
            flag_d   = flag_q;
            preset_d = preset_q;
            count_d  = count_q;

            // Software clear first so an expiry on the same edge overrides it.
            if (wr_ctrl && wdata[4]) begin
                flag_d = 1'b0;
            end

            case (state_q)
                S_IDLE: begin
                    if (en_q) begin
                        state_d = S_LOAD;
                    end
                end
                S_LOAD: begin
                    count_d = preset_q;
                    state_d = S_CNT;
                end
                S_CNT: begin
                    if (!en_q) begin
                        state_d = S_IDLE;
                    end else if (count_q > WIDTH'(1)) begin
                        count_d = count_q - WIDTH'(1);
                    end else begin
                        count_d = '0;
                        flag_d  = 1'b1;
                        state_d = S_INT;
                    end
                end
                S_INT: begin
                    if (mode_q == 2'b01) begin
                        state_d = en_q ? S_LOAD : S_IDLE;
                    end else begin
                        en_d    = 1'b0;
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase

            // A bus write of CTRL takes precedence over the one-shot auto-disable.
            if (wr_ctrl) begin
                en_d   = wdata[0];
                mode_d = wdata[2:1];
                im_d   = wdata[3];
            end
            if (wr_preset) begin
                preset_d = wdata[WIDTH-1:0];
            end
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                state_q  <= S_IDLE;
                en_q     <= 1'b0;
                mode_q   <= 2'b00;
                im_q     <= 1'b0;
                flag_q   <= 1'b0;
                preset_q <= '0;
                count_q  <= '0;
            end else begin
                state_q  <= state_d;
                en_q     <= en_d;
                mode_q   <= mode_d;
                im_q     <= im_d;
                flag_q   <= flag_d;
                preset_q <= preset_d;
                count_q  <= count_d;
            end
        end

        assign irq[gi]       = flag_q & im_q;
        assign ctrl_rd[gi]   = {27'd0, flag_q, im_q, mode_q, en_q};
        assign preset_rd[gi] = 32'(preset_q);
        assign count_rd[gi]  = 32'(count_q);
    end

    always_comb begin
        rdata = '0;
        for (int i = 0; i < NCH; i++) begin
            if (hit && (ch_sel == 3'(i))) begin
                case (word_sel)
                    2'd0:    rdata = ctrl_rd[i];
                    2'd1:    rdata = preset_rd[i];
                    2'd2:    rdata = count_rd[i];
                    default: rdata = '0;
                endcase
            end
        end
    end

    assign irq_any = |irq;

endmodule

// File: tb/tb_timer_nch.sv
// Self-checking bench for timer_nch: directed scenarios with literal expectations plus a
// randomized bus phase, all checked every cycle against an age-based channel model.
module tb_timer_nch;
    localparam int          NCH   = 3;
    localparam int          WIDTH = 16;
    localparam logic [31:0] BASE  = 32'h0000_7F00;
    localparam logic [31:0] MASK  = 32'h0000_FFFF;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           we = 1'b0;
    logic [31:2]    addr = '0;
    logic [31:0]    wdata = '0;
    logic [31:0]    rdata;
    logic [NCH-1:0] irq;
    logic           irq_any;

    int n_checks = 0;
    int n_fail   = 0;

    always #50 clk = ~clk;

    timer_nch #(.NCH(NCH), .WIDTH(WIDTH), .BASE(BASE)) dut (
        .clk(clk), .rst(rst), .addr(addr), .wdata(wdata), .we(we),
        .rdata(rdata), .irq(irq), .irq_any(irq_any)
    );

    // Model: a channel is either stopped (m_run=0) or on a run timeline where m_age is
    // the number of edges since the run (re)started: age 0 loads the preset, ages
    // 1..peff show a descending count, age peff+1 is the expiry cycle.
    bit        m_en   [NCH];
    bit [1:0]  m_mode [NCH];
    bit        m_im   [NCH];
    bit        m_flag [NCH];
    bit [31:0] m_preset [NCH];
    bit [31:0] m_count  [NCH];
    bit        m_run  [NCH];
    int        m_age  [NCH];
    int        m_peff [NCH];

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            m_en[c] = 0; m_mode[c] = 0; m_im[c] = 0; m_flag[c] = 0;
            m_preset[c] = 0; m_count[c] = 0; m_run[c] = 0; m_age[c] = 0; m_peff[c] = 1;
        end
    endtask

    function automatic logic [31:0] model_read(input logic [31:0] ba);
        logic [31:0] off;
        int c;
        off = ba - BASE;
        if (!((ba >= BASE) && (off < 32'(16 * NCH)))) return 32'd0;
        c = int'(off[6:4]);
        case (off[3:2])
            2'd0:    return {27'd0, m_flag[c], m_im[c], m_mode[c], m_en[c]};
            2'd1:    return m_preset[c];
            2'd2:    return m_count[c];
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [NCH-1:0] model_irq();
        logic [NCH-1:0] v;
        for (int c = 0; c < NCH; c++) v[c] = m_flag[c] & m_im[c];
        return v;
    endfunction

    task automatic model_step(input logic w, input logic [31:0] ba, input logic [31:0] d);
        logic [31:0] off;
        bit hit;
        off = ba - BASE;
        hit = (ba >= BASE) && (off < 32'(16 * NCH));
        for (int c = 0; c < NCH; c++) begin
            bit wr_ctrl, wr_pre, n_en, n_flag, n_run;
            bit [31:0] n_count;
            int n_age, n_peff;
            wr_ctrl = w && hit && (int'(off[6:4]) == c) && (off[3:2] == 2'd0);
            wr_pre  = w && hit && (int'(off[6:4]) == c) && (off[3:2] == 2'd1);
            n_en = m_en[c]; n_flag = m_flag[c]; n_run = m_run[c];
            n_count = m_count[c]; n_age = m_age[c]; n_peff = m_peff[c];
            if (wr_ctrl && d[4]) n_flag = 0;
            if (!m_run[c]) begin
                if (m_en[c]) begin n_run = 1; n_age = 0; end
            end else if (m_age[c] == 0) begin
                n_count = m_preset[c];
                n_peff  = (m_preset[c] == 0) ? 1 : int'(m_preset[c]);
                n_age   = 1;
            end else if (m_age[c] <= m_peff[c]) begin
                if (!m_en[c]) n_run = 0;
                else begin
                    n_age = m_age[c] + 1;
                    if (m_age[c] == m_peff[c]) begin n_count = 0; n_flag = 1; end
                    else n_count = 32'(m_peff[c] - m_age[c]);
                end
            end else begin
                if (m_mode[c] == 2'b01) begin
                    if (m_en[c]) n_age = 0; else n_run = 0;
                end else begin
                    n_en = 0; n_run = 0;
                end
            end
            if (wr_ctrl) begin
                n_en = d[0]; m_mode[c] = d[2:1]; m_im[c] = d[3];
            end
            if (wr_pre) m_preset[c] = d & MASK;
            m_en[c] = n_en; m_flag[c] = n_flag; m_run[c] = n_run;
            m_count[c] = n_count; m_age[c] = n_age; m_peff[c] = n_peff;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ca(input int ch, input int w);
        return BASE + 32'(16 * ch) + 32'(4 * w);
    endfunction

    // One bus cycle: drive, compare DUT against the model, advance model and clock.
    task automatic tick(input logic w, input logic [31:0] ba, input logic [31:0] d);
        we = w; addr = ba[31:2]; wdata = d;
        #1;
        chk("model_rdata", rdata, model_read(ba));
        chk("model_irq", 32'(irq), 32'(model_irq()));
        chk("model_irq_any", 32'(irq_any), 32'(|model_irq()));
        model_step(w, ba, d);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, ca(0, 2), 32'd0);
    endtask

    task automatic peek(input string name, input logic [31:0] ba, input logic [31:0] exp);
        we = 1'b0; addr = ba[31:2];
        #1;
        chk(name, rdata, exp);
    endtask

    initial begin
        logic [31:0] ba, d;
        logic        w;
        model_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        for (int c = 0; c < NCH; c++)
            for (int k = 0; k < 4; k++) peek("reset_read", ca(c, k), 32'd0);
        chk("reset_irq", 32'(irq), 32'd0);
        chk("reset_irq_any", 32'(irq_any), 32'd0);
        rst = 1'b1;

        // unmapped word just past the last channel
        peek("unmapped_read", ca(NCH, 0), 32'd0);
        tick(1'b1, ca(NCH, 0), 32'hFFFF_FFFF);
        tick(1'b1, ca(NCH, 1), 32'hFFFF_FFFF);
        for (int c = 0; c < NCH; c++)
            for (int k = 0; k < 4; k++) peek("unmapped_write_noeffect", ca(c, k), 32'd0);

        // ch0 one-shot, preset 5
        tick(1'b1, ca(0, 1), 32'd5);
        tick(1'b1, ca(0, 0), 32'h9);
        tick(1'b0, ca(0, 2), 32'd0);
        for (int k = 0; k < 6; k++) begin
            tick(1'b0, ca(0, 2), 32'd0);
            peek("oneshot_count", ca(0, 2), 32'(5 - k));
            chk("oneshot_irq0", 32'(irq[0]), 32'(k == 5));
        end
        peek("oneshot_ctrl_int", ca(0, 0), 32'h19);
        tick(1'b0, ca(0, 0), 32'd0);
        peek("oneshot_ctrl_done", ca(0, 0), 32'h18);
        tick(1'b1, ca(0, 0), 32'h10);
        chk("oneshot_irq_cleared", 32'(irq), 32'd0);

        // ch1 auto-reload, preset 3: expiries after E+5, E+10, E+15
        tick(1'b1, ca(1, 1), 32'd3);
        tick(1'b1, ca(1, 0), 32'hB);
        idle(4);
        chk("reload_irq_before", 32'(irq), 32'd0);
        idle(1);
        chk("reload_irq_first", 32'(irq), 32'b010);
        chk("reload_irq_any", 32'(irq_any), 32'd1);
        peek("reload_count_int", ca(1, 2), 32'd0);
        tick(1'b1, ca(1, 0), 32'h1B);
        chk("reload_clear", 32'(irq), 32'd0);
        peek("reload_count_load", ca(1, 2), 32'd0);
        idle(1);
        peek("reload_count_reloaded", ca(1, 2), 32'd3);
        idle(3);
        chk("reload_irq_second", 32'(irq), 32'b010);
        tick(1'b1, ca(1, 0), 32'h1B);
        chk("reload_clear2", 32'(irq), 32'd0);
        idle(3);
        tick(1'b1, ca(1, 0), 32'h1B);
        chk("set_beats_clear", 32'(irq), 32'b010);
        tick(1'b1, ca(1, 0), 32'h10);
        idle(4);
        chk("reload_stopped", 32'(irq), 32'd0);

        // preset 0 behaves like preset 1
        tick(1'b1, ca(0, 1), 32'd0);
        tick(1'b1, ca(0, 0), 32'h9);
        idle(2);
        chk("preset0_irq_early", 32'(irq), 32'd0);
        idle(1);
        chk("preset0_irq", 32'(irq), 32'b001);
        tick(1'b1, ca(0, 0), 32'h10);

        // disable mid-count, re-enable, then asynchronous reset
        tick(1'b1, ca(0, 1), 32'd100);
        tick(1'b1, ca(0, 0), 32'h1);
        idle(2);
        peek("long_count_start", ca(0, 2), 32'd100);
        idle(60);
        peek("long_count_40", ca(0, 2), 32'd40);
        tick(1'b1, ca(0, 0), 32'h0);
        peek("freeze_count", ca(0, 2), 32'd39);
        idle(2);
        peek("freeze_hold", ca(0, 2), 32'd39);
        tick(1'b1, ca(0, 0), 32'h1);
        idle(2);
        peek("reenable_reload", ca(0, 2), 32'd100);
        idle(2);
        rst = 1'b0;
        model_reset();
        for (int k = 0; k < 3; k++) peek("async_reset_ch0", ca(0, k), 32'd0);
        chk("async_reset_irq", 32'(irq), 32'd0);
        rst = 1'b1;
        idle(4);
        peek("after_reset_count", ca(0, 2), 32'd0);

        // ch1 flag with IM=0 never raises irq
        tick(1'b1, ca(0, 1), 32'd4);
        tick(1'b1, ca(1, 1), 32'd2);
        tick(1'b1, ca(1, 0), 32'h3);
        tick(1'b1, ca(0, 0), 32'h9);
        idle(3);
        peek("masked_ctrl1", ca(1, 0), 32'h13);
        chk("masked_irq", 32'(irq), 32'd0);
        chk("masked_irq_any", 32'(irq_any), 32'd0);
        idle(3);
        chk("mixed_irq", 32'(irq), 32'b001);
        chk("mixed_irq_any", 32'(irq_any), 32'd1);
        tick(1'b1, ca(0, 0), 32'h10);
        tick(1'b1, ca(1, 0), 32'h10);
        idle(3);

        // randomized bus traffic across all channels plus neighbouring unmapped words
        for (int i = 0; i < 3000; i++) begin
            ba = BASE - 32'd16 + 32'(4 * $urandom_range(0, 4 * NCH + 7));
            w  = ($urandom_range(0, 9) < 2);
            d  = $urandom;
            if (ba[3:2] == 2'd1) d = (d & 32'hFFFF_0000) | 32'($urandom_range(0, 12));
            tick(w, ba, d);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
